// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: control FSM state bit positions, LCD command
// codes and default widths used by the lap recorder and its neighbours.
package stopwatch_pkg;

    localparam int NUM_STATES = 11;

    localparam int ST_IDLE      = 0;
    localparam int ST_PRE_START = 1;
    localparam int ST_RUN       = 2;
    localparam int ST_PRE_PAUSE = 3;
    localparam int ST_PAUSE     = 4;
    localparam int ST_RETRIEVE  = 5;
    localparam int ST_SAVE      = 6;
    localparam int ST_PRE_RESET = 7;
    localparam int ST_RESET     = 8;
    localparam int ST_PRE_CLEAR = 9;
    localparam int ST_CLEAR     = 10;

    typedef enum logic [1:0] {
        LCD_NOP    = 2'b00,
        WRITE_LAP  = 2'b01,
        CLEAR_LAPS = 2'b10
    } lcd_cmd_e;

    localparam int DEF_LAPS       = 8;
    localparam int DEF_TW         = 24;
    localparam int DEF_RST_CYCLES = 4;

endpackage

// File: rtl/lap_recorder_if.sv
// Request/acknowledge write channel from the lap recorder to the LCD driver.
interface lap_recorder_if #(
    parameter int AW = 3,
    parameter int TW = 24
);
    logic          lcd_req;
    logic          lcd_ack;
    logic [1:0]    lcd_cmd;
    logic [AW-1:0] lcd_addr;
    logic [TW-1:0] lcd_data;

    modport master (output lcd_req, lcd_cmd, lcd_addr, lcd_data, input lcd_ack);
    modport slave  (input lcd_req, lcd_cmd, lcd_addr, lcd_data, output lcd_ack);
endinterface

// File: rtl/lap_ram.sv
// LAPS x TW lap register file: one synchronous write port, one async read port.
module lap_ram #(
    parameter  int LAPS = 8,
    parameter  int TW   = 24,
    localparam int AW   = $clog2(LAPS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [TW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [TW-1:0] o_rdata
);

    logic [TW-1:0] r_mem [LAPS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAPS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lap_recorder.sv
// Busy-handshake responder for the stopwatch FSM: records laps on SAVE entry,
// wipes them on CLEAR entry, pulses the timer clear on RESET entry.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter  int LAPS       = DEF_LAPS,
    parameter  int TW         = DEF_TW,
    parameter  int RST_CYCLES = DEF_RST_CYCLES,
    localparam int AW         = $clog2(LAPS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_STATES-1:0] state,
    input  logic [TW-1:0]         time_now,
    output logic                  lcd_busy,
    output logic                  reg_busy,
    output logic                  time_clr,
    output logic [AW:0]           lap_count,
    output logic                  overrun,
    lap_recorder_if.master        lcd
);

    localparam logic [2:0] J_IDLE     = 3'd0;
    localparam logic [2:0] J_SAVE_REQ = 3'd1;
    localparam logic [2:0] J_WIPE     = 3'd2;
    localparam logic [2:0] J_CLR_REQ  = 3'd3;
    localparam logic [2:0] J_RST      = 3'd4;

    localparam logic [AW:0]   CNT_MAX   = (AW+1)'(LAPS);
    localparam logic [AW-1:0] LAST_SLOT = AW'(LAPS-1);
    localparam logic [3:0]    RST_LOAD  = 4'(RST_CYCLES-1);

    logic [2:0]    r_job;
    logic          r_prev_save, r_prev_clr, r_prev_rst;
    logic [AW-1:0] r_wr_ptr, r_addr, r_wipe;
    logic [AW:0]   r_cnt;
    logic [3:0]    r_rst_cnt;
    logic          r_overrun;

    logic          w_ent_save, w_ent_clr, w_ent_rst, w_any_ent, w_idle;
    logic          w_go_save, w_go_clr, w_go_rst;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [TW-1:0] w_wdata, w_rdata;
    logic          w_unused_state;

    assign w_ent_save = state[ST_SAVE]  & ~r_prev_save;
    assign w_ent_clr  = state[ST_CLEAR] & ~r_prev_clr;
    assign w_ent_rst  = state[ST_RESET] & ~r_prev_rst;
    assign w_any_ent  = w_ent_save | w_ent_clr | w_ent_rst;
    assign w_idle     = (r_job == J_IDLE);

    // An entry that lands while a job is running is dropped, so it must not raise busy either.
    assign w_go_save = w_ent_save & w_idle;
    assign w_go_clr  = w_ent_clr  & w_idle;
    assign w_go_rst  = w_ent_rst  & w_idle;

    assign w_unused_state = ^{state[5:0], state[7], state[9]};

    assign lcd_busy = reset_n & (w_go_save | w_go_clr | (r_job == J_SAVE_REQ) |
                                 (r_job == J_WIPE) | (r_job == J_CLR_REQ));
    assign reg_busy = reset_n & (w_go_rst | (r_job == J_RST));
    assign time_clr = (r_job == J_RST);

    assign lap_count = r_cnt;
    assign overrun   = r_overrun;

    always_comb begin
        lcd.lcd_req  = 1'b0;
        lcd.lcd_cmd  = LCD_NOP;
        lcd.lcd_addr = '0;
        lcd.lcd_data = '0;
        if (r_job == J_SAVE_REQ) begin
            lcd.lcd_req  = 1'b1;
            lcd.lcd_cmd  = WRITE_LAP;
            lcd.lcd_addr = r_addr;
            lcd.lcd_data = w_rdata;
        end else if (r_job == J_CLR_REQ) begin
            lcd.lcd_req  = 1'b1;
            lcd.lcd_cmd  = CLEAR_LAPS;
        end
    end

    // Save and wipe never overlap, so one write port serves both.
    assign w_we    = w_go_save | (r_job == J_WIPE);
    assign w_waddr = (r_job == J_WIPE) ? r_wipe : r_wr_ptr;
    assign w_wdata = (r_job == J_WIPE) ? '0 : time_now;

    lap_ram #(.LAPS(LAPS), .TW(TW)) u_ram (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_job       <= J_IDLE;
            r_prev_save <= 1'b0;
            r_prev_clr  <= 1'b0;
            r_prev_rst  <= 1'b0;
            r_wr_ptr    <= '0;
            r_addr      <= '0;
            r_wipe      <= '0;
            r_cnt       <= '0;
            r_rst_cnt   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_prev_save <= state[ST_SAVE];
            r_prev_clr  <= state[ST_CLEAR];
            r_prev_rst  <= state[ST_RESET];
            if (w_any_ent && !w_idle) r_overrun <= 1'b1;

            case (r_job)
                J_IDLE: begin
                    if (w_go_save) begin
                        r_addr   <= r_wr_ptr;
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + (AW+1)'(1);
                        r_job    <= J_SAVE_REQ;
                    end else if (w_go_clr) begin
                        r_wipe <= '0;
                        r_job  <= J_WIPE;
                    end else if (w_go_rst) begin
                        r_wr_ptr  <= '0;
                        r_cnt     <= '0;
                        r_rst_cnt <= RST_LOAD;
                        r_job     <= J_RST;
                    end
                end
                J_SAVE_REQ: if (lcd.lcd_ack) r_job <= J_IDLE;
                J_WIPE: begin
                    if (r_wipe == LAST_SLOT) begin
                        r_wr_ptr <= '0;
                        r_cnt    <= '0;
                        r_job    <= J_CLR_REQ;
                    end else begin
                        r_wipe <= r_wipe + AW'(1);
                    end
                end
                J_CLR_REQ: if (lcd.lcd_ack) r_job <= J_IDLE;
                J_RST: begin
                    if (r_rst_cnt == 4'd0) r_job <= J_IDLE;
                    else                   r_rst_cnt <= r_rst_cnt - 4'd1;
                end
                default: r_job <= J_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder: save/ack timing, wrap, clear, reset pulse,
// overrun and asynchronous reset mid-wipe.
module tb_lap_recorder;
    import stopwatch_pkg::*;

    localparam logic [10:0] S_IDLE  = 11'b1 << ST_IDLE;
    localparam logic [10:0] S_RUN   = 11'b1 << ST_RUN;
    localparam logic [10:0] S_SAVE  = 11'b1 << ST_SAVE;
    localparam logic [10:0] S_RESET = 11'b1 << ST_RESET;
    localparam logic [10:0] S_CLEAR = 11'b1 << ST_CLEAR;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] state;
    logic [23:0] time_now;
    logic        lcd_busy, reg_busy, time_clr, overrun;
    logic [3:0]  lap_count;
    int          n_chk = 0;
    int          n_err = 0;

    lap_recorder_if #(.AW(3), .TW(24)) lcd_if ();

    lap_recorder #(.LAPS(8), .TW(24), .RST_CYCLES(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .state     (state),
        .time_now  (time_now),
        .lcd_busy  (lcd_busy),
        .reg_busy  (reg_busy),
        .time_clr  (time_clr),
        .lap_count (lap_count),
        .overrun   (overrun),
        .lcd       (lcd_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One SAVE entry acknowledged on the first request cycle.
    task automatic save_lap(input logic [23:0] ts, input logic [2:0] exp_addr, input logic [3:0] exp_cnt);
        state = S_RUN;
        cyc();
        state    = S_SAVE;
        time_now = ts;
        #1 chk("sv_busy_entry", lcd_busy, 1);
        cyc();
        chk("sv_req", lcd_if.lcd_req, 1);
        chk("sv_cmd", lcd_if.lcd_cmd, 2'b01);
        chk("sv_addr", lcd_if.lcd_addr, exp_addr);
        chk("sv_data", lcd_if.lcd_data, ts);
        chk("sv_cnt", lap_count, exp_cnt);
        lcd_if.lcd_ack = 1'b1;
        cyc();
        lcd_if.lcd_ack = 1'b0;
        chk("sv_req_done", lcd_if.lcd_req, 0);
        chk("sv_busy_done", lcd_busy, 0);
        state = S_RUN;
    endtask

    task automatic reset_entry();
        state = S_RUN;
        cyc();
        state = S_RESET;
        #1;
        chk("rs_regbusy_c1", reg_busy, 1);
        chk("rs_tclr_c1", time_clr, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("rs_regbusy_win", reg_busy, 1);
            chk("rs_tclr_win", time_clr, 1);
            cyc();
        end
        chk("rs_regbusy_end", reg_busy, 0);
        chk("rs_tclr_end", time_clr, 0);
        chk("rs_cnt", lap_count, 0);
        state = S_RUN;
    endtask

    initial begin
        reset_n        = 1'b0;
        state          = '0;
        time_now       = '0;
        lcd_if.lcd_ack = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", lcd_busy, 0);
        chk("rst_req", lcd_if.lcd_req, 0);
        chk("rst_cnt", lap_count, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        #1 chk("zero_vec_busy", lcd_busy, 0);
        cyc();

        // First save with a slow ack
        state    = S_SAVE;
        time_now = 24'h012345;
        #1 chk("t1_busy_same", lcd_busy, 1);
        cyc();
        chk("t1_req", lcd_if.lcd_req, 1);
        chk("t1_cmd", lcd_if.lcd_cmd, 2'b01);
        chk("t1_addr", lcd_if.lcd_addr, 0);
        chk("t1_data", lcd_if.lcd_data, 24'h012345);
        time_now = 24'h999999;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t1_hold_req", lcd_if.lcd_req, 1);
            chk("t1_hold_data", lcd_if.lcd_data, 24'h012345);
            chk("t1_hold_busy", lcd_busy, 1);
        end
        lcd_if.lcd_ack = 1'b1;
        cyc();
        lcd_if.lcd_ack = 1'b0;
        chk("t1_busy_drop", lcd_busy, 0);
        chk("t1_cnt", lap_count, 1);
        cyc();
        chk("t1_no_retrig", lcd_if.lcd_req, 0);

        // RESET keeps lap memory, rewinds the pointer
        reset_entry();
        chk("rs_mem_kept", dut.u_ram.r_mem[0], 24'h012345);

        // Nine saves: wrap onto slot 0, count saturates
        for (int i = 0; i < 9; i++)
            save_lap(24'h000100 + 24'(i), 3'(i % 8), 4'((i + 1 > 8) ? 8 : i + 1));
        chk("wrap_mem0", dut.u_ram.r_mem[0], 24'h000108);
        chk("wrap_mem1", dut.u_ram.r_mem[1], 24'h000101);

        // RESET entry while a save waits for ack
        state = S_RUN;
        cyc();
        state    = S_SAVE;
        time_now = 24'h055555;
        cyc();
        chk("ov_pre", overrun, 0);
        state = S_RESET;
        #1 chk("ov_regbusy_entry", reg_busy, 0);
        cyc();
        chk("ov_flag", overrun, 1);
        chk("ov_req", lcd_if.lcd_req, 1);
        chk("ov_addr", lcd_if.lcd_addr, 1);
        chk("ov_data", lcd_if.lcd_data, 24'h055555);
        for (int i = 0; i < 2; i++) begin
            chk("ov_tclr", time_clr, 0);
            chk("ov_regbusy", reg_busy, 0);
            cyc();
        end
        lcd_if.lcd_ack = 1'b1;
        cyc();
        lcd_if.lcd_ack = 1'b0;
        chk("ov_req_done", lcd_if.lcd_req, 0);
        chk("ov_cnt", lap_count, 8);
        cyc();
        chk("ov_regbusy_after", reg_busy, 0);
        chk("ov_tclr_after", time_clr, 0);

        // Three laps, then CLEAR
        reset_entry();
        save_lap(24'h010203, 3'd0, 4'd1);
        save_lap(24'h020304, 3'd1, 4'd2);
        save_lap(24'h030405, 3'd2, 4'd3);
        cyc();
        state = S_CLEAR;
        #1 chk("cl_busy_entry", lcd_busy, 1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("cl_wipe_busy", lcd_busy, 1);
            chk("cl_wipe_noreq", lcd_if.lcd_req, 0);
            cyc();
        end
        chk("cl_req", lcd_if.lcd_req, 1);
        chk("cl_cmd", lcd_if.lcd_cmd, 2'b10);
        chk("cl_addr", lcd_if.lcd_addr, 0);
        chk("cl_data", lcd_if.lcd_data, 0);
        chk("cl_busy_req", lcd_busy, 1);
        chk("cl_cnt", lap_count, 0);
        cyc();
        chk("cl_req_hold", lcd_if.lcd_req, 1);
        lcd_if.lcd_ack = 1'b1;
        cyc();
        lcd_if.lcd_ack = 1'b0;
        chk("cl_req_done", lcd_if.lcd_req, 0);
        chk("cl_busy_done", lcd_busy, 0);
        for (int i = 0; i < 8; i++) chk("cl_mem_zero", dut.u_ram.r_mem[i], 0);
        save_lap(24'h0A0B0C, 3'd0, 4'd1);

        // reset_n pulsed during a wipe
        cyc();
        state = S_CLEAR;
        cyc();
        cyc();
        cyc();
        chk("mr_busy_pre", lcd_busy, 1);
        reset_n = 1'b0;
        state   = S_IDLE;
        #1;
        chk("mr_busy", lcd_busy, 0);
        chk("mr_req", lcd_if.lcd_req, 0);
        chk("mr_cnt", lap_count, 0);
        chk("mr_ovr", overrun, 0);
        chk("mr_regbusy", reg_busy, 0);
        chk("mr_tclr", time_clr, 0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mr_post_busy", lcd_busy, 0);
            chk("mr_post_req", lcd_if.lcd_req, 0);
            cyc();
        end
        save_lap(24'h111111, 3'd0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Responder side of the stopwatch control FSM's busy handshake.
- Watches the FSM's one-hot state vector, acts on entry to SAVE, CLEAR and RESET, and drives the lcd_busy and reg_busy bits back into the FSM stimulus bundle.
- Owns the lap timestamp memory and the request/acknowledge write channel to the LCD driver.

Parameters:
- LAPS, 8, number of lap slots (power of two, 2..16).
- TW, 24, timestamp width: six BCD digits mm:ss:cc.
- RST_CYCLES, 4, length of the timer-clear pulse and reg_busy window on RESET entry (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- state  in  11  one-hot FSM state. Bit indices are fixed: IDLE=0, PRE_START=1, RUN=2, PRE_PAUSE=3, PAUSE=4, RETRIEVE=5, SAVE=6, PRE_RESET=7, RESET=8, PRE_CLEAR=9, CLEAR=10.
- time_now  in  TW  live timestamp from the timer.
- lcd_busy  out  1  to FSM stimulus[1].
- reg_busy  out  1  to FSM stimulus[0].
- time_clr  out  1  synchronous clear to the timer.
- lcd_req  out  1  LCD command valid.
- lcd_ack  in  1  LCD driver accepts the command.
- lcd_cmd  out  2  command: 01 = WRITE_LAP, 10 = CLEAR_LAPS.
- lcd_addr  out  log2(LAPS)  lap slot index.
- lcd_data  out  TW  lap timestamp.
- lap_count  out  log2(LAPS)+1  valid laps; saturates at LAPS.
- overrun  out  1  sticky: an entry arrived while a job was active.

Behaviour:
- Reset state (async, reset_n low):
  - All outputs 0; wr_ptr = 0; lap memory = 0; job FSM in J_IDLE.
  - Any request in flight is dropped; lcd_req falls immediately.
- Entry detection:
  - prev_state is registered each cycle.
  - entry_X = state[X] & ~prev_state[X], for X in {SAVE, CLEAR, RESET}.
- Busy outputs are combinational so the FSM sees busy in its first cycle of SAVE, CLEAR or RESET:
  - lcd_busy = entry_SAVE | entry_CLEAR | job in {J_SAVE_REQ, J_WIPE, J_CLR_REQ}.
  - reg_busy = entry_RESET | job == J_RST.
- Job FSM states: J_IDLE, J_SAVE_REQ, J_WIPE, J_CLR_REQ, J_RST.
- J_IDLE:
  - entry_SAVE: lap[wr_ptr] <= time_now (sampled in the entry cycle); latch addr = wr_ptr; wr_ptr <= wr_ptr+1 mod LAPS; lap_count <= min(lap_count+1, LAPS); go J_SAVE_REQ.
  - entry_CLEAR: wipe index <= 0; go J_WIPE.
  - entry_RESET: wr_ptr <= 0; lap_count <= 0; counter <= RST_CYCLES-1; go J_RST. Lap memory is kept.
- J_SAVE_REQ:
  - lcd_req = 1, lcd_cmd = 01, lcd_addr = latched slot, lcd_data = stored lap.
  - All held stable until lcd_ack is sampled high; handshake completes on that edge; then J_IDLE.
- J_WIPE:
  - Writes 0 to one slot per cycle, indices 0..LAPS-1, taking exactly LAPS cycles.
  - Then wr_ptr <= 0, lap_count <= 0; go J_CLR_REQ.
- J_CLR_REQ:
  - lcd_req = 1, lcd_cmd = 10, lcd_addr = 0, lcd_data = 0.
  - On the lcd_ack edge, go J_IDLE.
- J_RST:
  - time_clr = 1 for exactly RST_CYCLES cycles, starting the cycle after entry.
  - Counter reaching 0 leaves for J_IDLE.
- lcd_req is 0 outside J_SAVE_REQ and J_CLR_REQ.
- lcd_ack while lcd_req = 0 is ignored.
- Ack latency is unbounded; the FSM stays in SAVE/CLEAR for the whole wait, held there by lcd_busy.
- Boundary conditions:
  - Any entry_X while job != J_IDLE: ignored (no state change), overrun <= 1 until reset.
  - wr_ptr wraps to 0 after slot LAPS-1; the oldest lap is overwritten.
  - state is assumed one-hot; the non-one-hot case is not tracked.
  - Zero vector (e.g. after FSM power-up) causes no entry.
  - Continuous SAVE across a job does not retrigger; a new entry requires a 0-to-1 edge of state[SAVE].
  - reset_n asserted mid-handshake aborts the handshake; after release the block restarts in J_IDLE with lcd_req = 0.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state bit-index constants, shared with control_fsm;
  - LCD command codes WRITE_LAP and CLEAR_LAPS;
  - default widths.
- One natural sub-module: lap_ram, an LAPS x TW register file with one write port and one async read port, also used by the display scroller.

Test Plan:
- Reset, then state = bit6 at time_now = 24'h012345:
  - lcd_busy is 1 in that same cycle.
  - lcd_req rises next cycle with cmd 01, addr 0, data 012345.
  - Hold lcd_ack = 0 for 5 cycles: outputs stay stable.
  - lcd_ack = 1: lcd_busy drops the cycle after; lap_count = 1.
- Nine SAVE entries with immediate ack (LAPS = 8):
  - The ninth writes addr 0.
  - lap_count stays 8.
  - lap[0] holds the ninth timestamp.
- CLEAR entry after 3 laps:
  - lcd_busy is high for 8 wipe cycles plus the request.
  - cmd 10 is issued; after ack all slots are 0 and lap_count = 0.
- RESET entry:
  - reg_busy is 1 for 1 + 4 cycles.
  - time_clr is high for exactly cycles 2..5.
  - wr_ptr = 0; lap contents are unchanged.
- entry_RESET while J_SAVE_REQ waits for ack:
  - reg_busy stays 0 and time_clr stays 0.
  - overrun = 1.
  - The save completes normally.
- reset_n pulsed low mid-wipe:
  - Outputs are 0 asynchronously.
  - After release, lcd_busy = 0 and no lcd_req until the next entry edge.
